// File: rtl/dec_cond_pkg.sv
// Shared types and default timing constants for the decrement button conditioner.
package dec_cond_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEB_PRESS,
    HELD,
    DEB_RELEASE
  } dec_state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer with a configurable reset level.
module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/dec_conditioner.sv
// Debounces an active-low push-button into one-cycle decrement pulses and a held level.
// Define DEC_CONDITIONER_AUTOREPEAT_EN to add auto-repeat pulses while the button is held.
module dec_conditioner
  import dec_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic dec,
  output logic pressed
);

  localparam int unsigned DebW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DebW-1:0] DebMax = DebW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
    $error("dec_conditioner: timing parameters must be 2 or more");
  end

  dec_state_t      r_state;
  logic [DebW-1:0] r_cnt;
  logic            r_dec;
  logic            r_pressed;
  logic            w_btn_raw_s;
  logic            w_btn_s;
  logic            w_rep_fire;

  // Raw button idles high, so the synchronizer resets to the released level.
  sync2 #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .i_clk(clk),
    .i_rst(rst),
    .i_d  (btn),
    .o_q  (w_btn_raw_s)
  );

  assign w_btn_s = ~w_btn_raw_s;

`ifdef DEC_CONDITIONER_AUTOREPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RepW   = $clog2(RepMax);

  logic [RepW-1:0] r_rep_cnt;
  logic            r_rep_phase;
  logic [RepW-1:0] w_rep_target;
  logic            w_in_hold;

  assign w_in_hold    = (r_state == HELD) && w_btn_s;
  assign w_rep_target = r_rep_phase ? RepW'(REPEAT_PERIOD - 1) : RepW'(REPEAT_DELAY - 1);
  assign w_rep_fire   = w_in_hold && (r_rep_cnt == w_rep_target);

  // Phase 0 times the initial delay, phase 1 the steady repeat period.
  always_ff @(posedge clk) begin
    if (!rst || !w_in_hold) begin
      r_rep_cnt   <= '0;
      r_rep_phase <= 1'b0;
    end else if (w_rep_fire) begin
      r_rep_cnt   <= '0;
      r_rep_phase <= 1'b1;
    end else begin
      r_rep_cnt <= r_rep_cnt + RepW'(1);
    end
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_dec     <= 1'b0;
      r_pressed <= 1'b0;
    end else begin
      r_dec <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_btn_s) begin
            r_state <= DEB_PRESS;
            r_cnt   <= '0;
          end
        end
        DEB_PRESS: begin
          if (!w_btn_s) begin
            r_state <= IDLE;
          end else if (r_cnt == DebMax) begin
            r_state   <= HELD;
            r_dec     <= 1'b1;
            r_pressed <= 1'b1;
          end else begin
            r_cnt <= r_cnt + DebW'(1);
          end
        end
        HELD: begin
          if (!w_btn_s) begin
            r_state <= DEB_RELEASE;
            r_cnt   <= '0;
          end else if (w_rep_fire) begin
            r_dec <= 1'b1;
          end
        end
        DEB_RELEASE: begin
          if (w_btn_s) begin
            r_state <= HELD;
          end else if (r_cnt == DebMax) begin
            r_state   <= IDLE;
            r_pressed <= 1'b0;
          end else begin
            r_cnt <= r_cnt + DebW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dec     = r_dec;
  assign pressed = r_pressed;

endmodule

// File: tb/tb_dec_conditioner.sv
// Scoreboard bench for dec_conditioner: expected pulse cycles are queued, the monitor pops them.
module tb_dec_conditioner;

  localparam int unsigned DEB = 4;
  localparam int unsigned RD  = 20;
  localparam int unsigned RP  = 8;

  logic clk = 1'b0;
  logic rst;
  logic btn;
  logic dec;
  logic pressed;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_q[$];
  int   mon_exp;
  logic prev_dec;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dec_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn    (btn),
    .dec    (dec),
    .pressed(pressed)
  );

  // Pulse at HELD entry, plus auto-repeat pulses strictly before the edge that leaves HELD.
  function automatic void push_hold(int entry, int leave);
    exp_q.push_back(entry);
`ifdef DEC_CONDITIONER_AUTOREPEAT_EN
    for (int t = entry + int'(RD); t < leave; t += int'(RP)) exp_q.push_back(t);
`else
    if (leave < entry) exp_q.push_back(-1);
`endif
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    btn = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (dec !== 1'b0) begin
      n_err++;
      $display("FAIL reset_dec: got %b, required 0", dec);
    end
    n_vec++;
    if (pressed !== 1'b0) begin
      n_err++;
      $display("FAIL reset_pressed: got %b, required 0", pressed);
    end
    rst = 1'b1;
    repeat (4) @(negedge clk);
    n_vec++;
    if (dec !== 1'b0 || pressed !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: got dec=%b pressed=%b, required 0/0", dec, pressed);
    end
  endtask

  task automatic test_clean_press();
    int e0, r0;
    logic exp_p;
    @(negedge clk);
    btn = 1'b0;
    e0  = cyc + 1;
    push_hold(e0 + 6, e0 + 32);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      exp_p = (cyc >= e0 + 6);
      n_vec++;
      if (pressed !== exp_p) begin
        n_err++;
        $display("FAIL clean_pressed@%0d: got %b, required %b", cyc - e0, pressed, exp_p);
      end
    end
    btn = 1'b1;
    r0  = cyc + 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      exp_p = (cyc < r0 + 6);
      n_vec++;
      if (pressed !== exp_p) begin
        n_err++;
        $display("FAIL clean_release@%0d: got %b, required %b", cyc - r0, pressed, exp_p);
      end
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL clean_pending: %0d pulses missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_press_bounce();
    int f;
    logic exp_p;
    @(negedge clk);
    btn = 1'b0;
    repeat (2) @(negedge clk);
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
    f   = cyc + 1;
    push_hold(f + 6, f + 16);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      exp_p = (cyc >= f + 6);
      n_vec++;
      if (pressed !== exp_p) begin
        n_err++;
        $display("FAIL bounce_pressed@%0d: got %b, required %b", cyc - f, pressed, exp_p);
      end
    end
    btn = 1'b1;
    repeat (10) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0 || pressed !== 1'b0) begin
      n_err++;
      $display("FAIL bounce_end: got pending=%0d pressed=%b, required 0/0", exp_q.size(), pressed);
      exp_q.delete();
    end
  endtask

  task automatic test_short_glitch();
    @(negedge clk);
    btn = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i == 2) btn = 1'b1;
      n_vec++;
      if (pressed !== 1'b0) begin
        n_err++;
        $display("FAIL glitch_pressed@%0d: got %b, required 0", i, pressed);
      end
    end
  endtask

  task automatic test_release_bounce();
    int e0;
    logic exp_p;
    @(negedge clk);
    btn = 1'b0;
    e0  = cyc + 1;
    push_hold(e0 + 6, e0 + 14);
    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      exp_p = (cyc >= e0 + 6);
      n_vec++;
      if (pressed !== exp_p) begin
        n_err++;
        $display("FAIL relbounce_pressed@%0d: got %b, required %b", cyc - e0, pressed, exp_p);
      end
      if (cyc == e0 + 11) btn = 1'b1;
      if (cyc == e0 + 13) btn = 1'b0;
    end
    btn = 1'b1;
    repeat (10) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0 || pressed !== 1'b0) begin
      n_err++;
      $display("FAIL relbounce_end: got pending=%0d pressed=%b, required 0/0", exp_q.size(),
               pressed);
      exp_q.delete();
    end
  endtask

`ifdef DEC_CONDITIONER_AUTOREPEAT_EN
  task automatic test_autorepeat();
    int e0;
    logic exp_p;
    @(negedge clk);
    btn = 1'b0;
    e0  = cyc + 1;
    push_hold(e0 + 6, e0 + 62);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      exp_p = (cyc >= e0 + 6);
      n_vec++;
      if (pressed !== exp_p) begin
        n_err++;
        $display("FAIL repeat_pressed@%0d: got %b, required %b", cyc - e0, pressed, exp_p);
      end
    end
    btn = 1'b1;
    repeat (10) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL repeat_pending: %0d pulses missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask
`endif

  task automatic test_reset_mid_hold();
    int e0;
    logic exp_p;
    @(negedge clk);
    btn = 1'b0;
    e0  = cyc + 1;
    exp_q.push_back(e0 + 6);
    push_hold(e0 + 18, e0 + 28);
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      exp_p = ((cyc >= e0 + 6) && (cyc <= e0 + 9)) || (cyc >= e0 + 18);
      n_vec++;
      if (pressed !== exp_p) begin
        n_err++;
        $display("FAIL rsthold_pressed@%0d: got %b, required %b", cyc - e0, pressed, exp_p);
      end
      if (cyc == e0 + 10 || cyc == e0 + 11) begin
        n_vec++;
        if (dec !== 1'b0) begin
          n_err++;
          $display("FAIL rsthold_dec@%0d: got %b, required 0", cyc - e0, dec);
        end
      end
      if (cyc == e0 + 9) rst = 1'b0;
      if (cyc == e0 + 11) rst = 1'b1;
    end
    btn = 1'b1;
    repeat (10) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0 || pressed !== 1'b0) begin
      n_err++;
      $display("FAIL rsthold_end: got pending=%0d pressed=%b, required 0/0", exp_q.size(),
               pressed);
      exp_q.delete();
    end
  endtask

  initial begin
    rst      = 1'b0;
    btn      = 1'b1;
    prev_dec = 1'b0;
    fork
      forever begin
        @(negedge clk);
        if (dec === 1'b1) begin
          n_vec++;
          if (prev_dec === 1'b1) begin
            n_err++;
            $display("FAIL dec_double: high at cycles %0d and %0d, required one cycle", cyc - 1,
                     cyc);
          end
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL dec_unexpected: pulse at cycle %0d, required none", cyc);
          end else begin
            mon_exp = exp_q.pop_front();
            if (cyc != mon_exp) begin
              n_err++;
              $display("FAIL dec_timing: pulse at cycle %0d, required cycle %0d", cyc, mon_exp);
            end
          end
        end
        prev_dec = dec;
      end
    join_none
    test_reset();
    test_clean_press();
    test_press_bounce();
    test_short_glitch();
    test_release_bounce();
`ifdef DEC_CONDITIONER_AUTOREPEAT_EN
    test_autorepeat();
`endif
    test_reset_mid_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
